// File: rtl/mmio_timer_bank.sv
// Bank of memory-mapped timers. Each channel has a reload value, a counter, control/status
// and a prescaler. The read mux is combinational; writes land on the clock edge.
module mmio_timer_bank #(
  parameter int unsigned NUM_TIMERS     = 2,
  parameter int unsigned TIMER_WIDTH    = 32,
  parameter int unsigned PRESCALE_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  rd_hit,
  output logic [NUM_TIMERS-1:0] irq,
  output logic                  interrupt
);

  localparam logic [31:0] SPAN = 32'(16 * NUM_TIMERS);

  logic [31:0] offset;
  logic        hit;
  logic [2:0]  sel_ch;
  logic [1:0]  sel_reg;
  logic [31:0] rd_regs [NUM_TIMERS][4];
  logic        unused_mem_read;

  assign unused_mem_read = mem_read;
  assign offset          = addr - BASE_ADDR;
  assign hit             = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) && (offset < SPAN);
  assign sel_ch          = offset[6:4];
  assign sel_reg         = offset[3:2];
  assign rd_hit          = hit;

  for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
    logic [TIMER_WIDTH-1:0]    th_q, th_d, tl_q, tl_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d, pc_q, pc_d;
    logic                      en_q, en_d, ien_q, ien_d, pend_q, pend_d, os_q, os_d;
    logic                      wsel, tick, ovf;

    assign wsel = mem_write && hit && (sel_ch == 3'(gi));
    assign tick = en_q && (pc_q == presc_q);
    assign ovf  = tick && (tl_q == '1);

    always_comb begin
      th_d    = th_q;
      tl_d    = tl_q;
      presc_d = presc_q;
      en_d    = en_q;
      ien_d   = ien_q;
      pend_d  = pend_q;
      os_d    = os_q;
      pc_d    = '0;

      if (tick) tl_d = ovf ? th_q : tl_q + TIMER_WIDTH'(1);
      if (ovf) begin
        pend_d = 1'b1;
        if (os_q) en_d = 1'b0;
      end

      if (wsel && sel_reg == 2'd0) th_d = wr_data[TIMER_WIDTH-1:0];
      if (wsel && sel_reg == 2'd1) tl_d = wr_data[TIMER_WIDTH-1:0];
      // W1C of pending yields to a same-cycle overflow so no event is dropped
      if (wsel && sel_reg == 2'd2) begin
        en_d  = wr_data[0];
        ien_d = wr_data[1];
        os_d  = wr_data[3];
        if (wr_data[2] && !ovf) pend_d = 1'b0;
      end
      if (wsel && sel_reg == 2'd3) presc_d = wr_data[PRESCALE_WIDTH-1:0];

      if (!(wsel && sel_reg == 2'd3) && en_d && en_q && !tick)
        pc_d = pc_q + PRESCALE_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        th_q    <= '0;
        tl_q    <= '0;
        presc_q <= '0;
        pc_q    <= '0;
        en_q    <= 1'b0;
        ien_q   <= 1'b0;
        pend_q  <= 1'b0;
        os_q    <= 1'b0;
      end else begin
        th_q    <= th_d;
        tl_q    <= tl_d;
        presc_q <= presc_d;
        pc_q    <= pc_d;
        en_q    <= en_d;
        ien_q   <= ien_d;
        pend_q  <= pend_d;
        os_q    <= os_d;
      end
    end

    assign rd_regs[gi][0] = 32'(th_q);
    assign rd_regs[gi][1] = 32'(tl_q);
    assign rd_regs[gi][2] = {28'b0, os_q, pend_q, ien_q, en_q};
    assign rd_regs[gi][3] = 32'(presc_q);
    assign irq[gi]        = pend_q & ien_q;
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
        if (sel_ch == 3'(i)) rd_data = rd_regs[i][sel_reg];
      end
    end
  end

  assign interrupt = |irq;

endmodule
